// File: rtl/cdec_pkg.sv
// rtl/cdec_pkg.sv - shared codes and types for the parametrised CDEC datapath
package cdec_pkg;

  localparam logic [4:0] XS_PC    = 5'd0;
  localparam logic [4:0] XS_R     = 5'd1;
  localparam logic [4:0] XS_RDR   = 5'd2;
  localparam logic [4:0] XS_FLG   = 5'd3;
  localparam logic [4:0] XS_IPORT = 5'd4;
  localparam logic [4:0] XS_SP    = 5'd5;
  localparam int         XS_GPR   = 16;

  localparam logic [4:0] XD_PC    = 5'd0;
  localparam logic [4:0] XD_I     = 5'd1;
  localparam logic [4:0] XD_T     = 5'd2;
  localparam logic [4:0] XD_MAR   = 5'd3;
  localparam logic [4:0] XD_WDR   = 5'd4;
  localparam logic [4:0] XD_OPORT = 5'd5;
  localparam logic [4:0] XD_SP    = 5'd6;
  localparam int         XD_GPR   = 16;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBC   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_PASSX = 4'hA;
  localparam logic [3:0] OP_PASSY = 4'hB;

  localparam logic [1:0] SP_INC   = 2'b01;
  localparam logic [1:0] SP_DEC   = 2'b10;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} mem_state_e;

  localparam logic [7:0] DBG_PC    = 8'h00;
  localparam logic [7:0] DBG_I     = 8'h01;
  localparam logic [7:0] DBG_T     = 8'h02;
  localparam logic [7:0] DBG_R     = 8'h03;
  localparam logic [7:0] DBG_MAR   = 8'h04;
  localparam logic [7:0] DBG_DIN   = 8'h05;
  localparam logic [7:0] DBG_RDR   = 8'h06;
  localparam logic [7:0] DBG_WDR   = 8'h07;
  localparam logic [7:0] DBG_SP    = 8'h08;
  localparam logic [7:0] DBG_FLG   = 8'h09;
  localparam logic [7:0] DBG_XBUS  = 8'h0A;
  localparam logic [7:0] DBG_IPORT = 8'h0B;
  localparam logic [7:0] DBG_STAT  = 8'h0C;
  localparam int         DBG_GPR   = 16;

endpackage

// File: rtl/cdecn_dp_if.sv
// rtl/cdecn_dp_if.sv - memory handshake bus between datapath and memory/IO bridge
interface cdecn_dp_if #(parameter int DATA_W = 8);
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;
  logic [DATA_W-1:0] adrs;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;

  modport master (output mem_req, mem_we, adrs, data_out, input mem_ack, data_in);
  modport slave  (input mem_req, mem_we, adrs, data_out, output mem_ack, data_in);
endinterface

// File: rtl/cdecn_alu.sv
// rtl/cdecn_alu.sv - combinational ALU producing result and {S,Z,C,V}
module cdecn_alu
  import cdec_pkg::*;
#(parameter int DATA_W = 8) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] res_o,
  output logic [3:0]        szcv_o
);
  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            is_add, is_sub, c, v;

  always_comb begin
    res_o  = x_i;
    sum    = '0;
    is_add = 1'b0;
    is_sub = 1'b0;
    c      = 1'b0;
    v      = 1'b0;
    case (op_i)
      OP_ADD:   begin sum = {1'b0, x_i} + {1'b0, y_i}; is_add = 1'b1; end
      OP_ADC:   begin sum = {1'b0, x_i} + {1'b0, y_i} + (DATA_W+1)'(cin_i); is_add = 1'b1; end
      OP_SUB:   begin sum = {1'b0, x_i} - {1'b0, y_i}; is_sub = 1'b1; end
      OP_SBC:   begin sum = {1'b0, x_i} - {1'b0, y_i} - (DATA_W+1)'(cin_i); is_sub = 1'b1; end
      OP_AND:   res_o = x_i & y_i;
      OP_OR:    res_o = x_i | y_i;
      OP_XOR:   res_o = x_i ^ y_i;
      OP_NOT:   res_o = ~x_i;
      OP_SHL:   begin res_o = {x_i[M-1:0], 1'b0}; c = x_i[M]; end
      OP_SHR:   begin res_o = {1'b0, x_i[M:1]}; c = x_i[0]; end
      OP_PASSX: res_o = x_i;
      OP_PASSY: res_o = y_i;
      default:  res_o = x_i;
    endcase
    // sum[DATA_W] is carry for add and borrow for subtract
    if (is_add || is_sub) begin
      res_o = sum[M:0];
      c     = sum[DATA_W];
      if (is_add) v = (x_i[M] == y_i[M]) && (res_o[M] != x_i[M]);
      else        v = (x_i[M] != y_i[M]) && (res_o[M] != x_i[M]);
    end
  end

  assign szcv_o = {res_o[M], res_o == '0, c, v};
endmodule

// File: rtl/cdecn_dp.sv
// rtl/cdecn_dp.sv - CDEC datapath: registers, XBUS, SP, debug mux and memory wait-state FSM
module cdecn_dp
  import cdec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NGPR    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic [4:0]        xsrc,
  input  logic [4:0]        xdst,
  input  logic [3:0]        aluop,
  input  logic              rwr,
  input  logic              fwr,
  input  logic [1:0]        sp_op,
  input  logic              mem_rd,
  input  logic              mem_wr,
  cdecn_dp_if.master        mem,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] I,
  output logic [3:0]        SZCV,
  output logic              busy,
  output logic              mem_err,
  input  logic [7:0]        resad,
  output logic [DATA_W-1:0] resdt
);
  logic [DATA_W-1:0] pc_q, i_q, t_q, r_q, mar_q, wdr_q, oport_q, sp_q, rdr_q, iport_q;
  logic [DATA_W-1:0] gpr_q [NGPR];
  logic [3:0]        flg_q;
  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d, err_q, err_d;
  logic [DATA_W-1:0] rdr_d, xbus, alu_res;
  logic [3:0]        alu_flg;

  always_comb begin
    xbus = '1;
    case (xsrc)
      XS_PC:    xbus = pc_q;
      XS_R:     xbus = r_q;
      XS_RDR:   xbus = rdr_q;
      XS_FLG:   xbus = {{(DATA_W-4){1'b0}}, flg_q};
      XS_IPORT: xbus = iport_q;
      XS_SP:    xbus = sp_q;
      default:  for (int k = 0; k < NGPR; k++) if (xsrc == 5'(XS_GPR + k)) xbus = gpr_q[k];
    endcase
  end

  cdecn_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i(aluop), .x_i(xbus), .y_i(t_q), .cin_i(flg_q[1]), .res_o(alu_res), .szcv_o(alu_flg)
  );

  // Counter starts at 1 in the first WAIT cycle; ack wins over timeout on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    rdr_d   = rdr_q;
    case (state_q)
      ST_IDLE: if (mem_rd || mem_wr) begin
        state_d = ST_WAIT;
        cnt_d   = 8'd1;
        we_d    = mem_wr;
      end
      ST_WAIT: if (mem.mem_ack) begin
        state_d = ST_IDLE;
        if (!we_q) rdr_d = mem.data_in;
      end else if (cnt_q == 8'(TIMEOUT)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pc_q <= '0; i_q <= '0; t_q <= '0; r_q <= '0; mar_q <= '0; wdr_q <= '0;
      oport_q <= '0; sp_q <= '1; rdr_q <= '0; iport_q <= '0; flg_q <= '0;
      for (int k = 0; k < NGPR; k++) gpr_q[k] <= '0;
      state_q <= ST_IDLE; cnt_q <= '0; we_q <= 1'b0; err_q <= 1'b0;
    end else begin
      iport_q <= io_in;
      if (rwr) r_q <= alu_res;
      if (fwr) flg_q <= alu_flg;
      case (xdst)
        XD_PC:    pc_q <= xbus;
        XD_I:     i_q <= xbus;
        XD_T:     t_q <= xbus;
        XD_MAR:   if (!busy) mar_q <= xbus;
        XD_WDR:   if (!busy) wdr_q <= xbus;
        XD_OPORT: oport_q <= xbus;
        default:  for (int k = 0; k < NGPR; k++) if (xdst == 5'(XD_GPR + k)) gpr_q[k] <= xbus;
      endcase
      if (xdst == XD_SP)       sp_q <= xbus;
      else if (sp_op == SP_INC) sp_q <= sp_q + 1'b1;
      else if (sp_op == SP_DEC) sp_q <= sp_q - 1'b1;
      state_q <= state_d; cnt_q <= cnt_d; we_q <= we_d; err_q <= err_d; rdr_q <= rdr_d;
    end
  end

  always_comb begin
    resdt = '0;
    case (resad)
      DBG_PC:    resdt = pc_q;
      DBG_I:     resdt = i_q;
      DBG_T:     resdt = t_q;
      DBG_R:     resdt = r_q;
      DBG_MAR:   resdt = mar_q;
      DBG_DIN:   resdt = mem.data_in;
      DBG_RDR:   resdt = rdr_q;
      DBG_WDR:   resdt = wdr_q;
      DBG_SP:    resdt = sp_q;
      DBG_FLG:   resdt = {{(DATA_W-4){1'b0}}, flg_q};
      DBG_XBUS:  resdt = xbus;
      DBG_IPORT: resdt = iport_q;
      DBG_STAT:  resdt = {{(DATA_W-2){1'b0}}, state_q, err_q};
      default:   for (int k = 0; k < NGPR; k++) if (resad == 8'(DBG_GPR + k)) resdt = gpr_q[k];
    endcase
  end

  assign busy         = (state_q == ST_WAIT);
  assign mem.mem_req  = busy;
  assign mem.mem_we   = we_q;
  assign mem.adrs     = mar_q;
  assign mem.data_out = wdr_q;
  assign io_out       = oport_q;
  assign I            = i_q;
  assign SZCV         = flg_q;
  assign mem_err      = err_q;
endmodule

// File: tb/tb_cdecn_dp.sv
// tb/tb_cdecn_dp.sv - directed self-checking bench for cdecn_dp (DATA_W=8, NGPR=4, TIMEOUT=15)
module tb_cdecn_dp;
  logic       clock, reset_N;
  logic [4:0] xsrc, xdst;
  logic [3:0] aluop;
  logic       rwr, fwr, mem_rd, mem_wr;
  logic [1:0] sp_op;
  logic [7:0] io_in, io_out, I, resdt, din;
  logic [3:0] SZCV;
  logic       busy, mem_err, ack_tie, ack_man;
  logic [7:0] resad;
  int         total, passed, cyc;

  cdecn_dp_if #(.DATA_W(8)) mif ();
  assign mif.mem_ack = ack_tie ? mif.mem_req : ack_man;
  assign mif.data_in = din;

  cdecn_dp #(.DATA_W(8), .NGPR(4), .TIMEOUT(15)) dut (
    .clock(clock), .reset_N(reset_N), .xsrc(xsrc), .xdst(xdst), .aluop(aluop),
    .rwr(rwr), .fwr(fwr), .sp_op(sp_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem(mif),
    .io_in(io_in), .io_out(io_out), .I(I), .SZCV(SZCV), .busy(busy),
    .mem_err(mem_err), .resad(resad), .resdt(resdt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
    resad = a;
    #1;
    chk(tag, 32'(resdt), exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0; passed = 0;
    reset_N = 1'b0; xsrc = 5'd31; xdst = 5'd31; aluop = 4'h0; rwr = 0; fwr = 0;
    sp_op = 2'b00; mem_rd = 0; mem_wr = 0; io_in = 8'h00; din = 8'h00;
    ack_tie = 0; ack_man = 0; resad = 8'h00;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_we", 32'(mif.mem_we), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_adrs", 32'(mif.adrs), 0);
    chk("rst_dout", 32'(mif.data_out), 0);
    rd(8'h08, "rst_sp", 'hFF);
    rd(8'h0A, "xbus_undef_src", 'hFF);
    reset_N = 1'b1;

    io_in = 8'h7F; step();
    xsrc = 5'd4; xdst = 5'd16; step();
    rd(8'h10, "gpr0_load", 'h7F);
    io_in = 8'h01; xdst = 5'd31; step();
    xdst = 5'd2; step();
    rd(8'h02, "t_load", 'h01);
    xsrc = 5'd16; xdst = 5'd31; aluop = 4'h0; rwr = 1; fwr = 1; step();
    rd(8'h03, "add_r", 'h80);
    chk("add_szcv", 32'(SZCV), 'b1001);
    rwr = 0; fwr = 0; xsrc = 5'd31; io_in = 8'h00; step();
    xsrc = 5'd4; aluop = 4'h2; rwr = 1; fwr = 1; step();
    rd(8'h03, "sub_r", 'hFF);
    chk("sub_szcv", 32'(SZCV), 'b1010);
    rwr = 0; fwr = 0; xsrc = 5'd1; xdst = 5'd1; step();
    chk("i_load", 32'(I), 'hFF);
    xdst = 5'd5; step();
    chk("oport_load", 32'(io_out), 'hFF);

    xdst = 5'd31; sp_op = 2'b01; step();
    rd(8'h08, "sp_inc_wrap", 'h00);
    sp_op = 2'b00; io_in = 8'h40; step();
    xsrc = 5'd4; xdst = 5'd6; sp_op = 2'b10; step();
    rd(8'h08, "sp_xdst_override", 'h40);
    xdst = 5'd31; step();
    rd(8'h08, "sp_dec", 'h3F);
    sp_op = 2'b00;

    io_in = 8'h12; step();
    xdst = 5'd3; step();
    chk("mar_load", 32'(mif.adrs), 'h12);
    xdst = 5'd31; ack_tie = 1; din = 8'hA5; mem_rd = 1; step();
    mem_rd = 0;
    chk("zw_req", 32'(mif.mem_req), 1);
    chk("zw_busy", 32'(busy), 1);
    chk("zw_we", 32'(mif.mem_we), 0);
    step();
    chk("zw_req_done", 32'(mif.mem_req), 0);
    rd(8'h06, "zw_rdr", 'hA5);

    ack_tie = 0; ack_man = 0; io_in = 8'h5A; step();
    xdst = 5'd4; step();
    chk("wdr_load", 32'(mif.data_out), 'h5A);
    xdst = 5'd31; mem_wr = 1; step();
    mem_wr = 0;
    chk("w3_busy1", 32'(busy), 1);
    chk("w3_we1", 32'(mif.mem_we), 1);
    io_in = 8'h77; step();
    chk("w3_busy2", 32'(busy), 1);
    xdst = 5'd3; step();
    chk("w3_busy3", 32'(busy), 1);
    chk("w3_adrs_stable", 32'(mif.adrs), 'h12);
    chk("w3_we3", 32'(mif.mem_we), 1);
    xdst = 5'd31; ack_man = 1; step();
    ack_man = 0;
    chk("w3_done", 32'(busy), 0);
    chk("w3_adrs_after", 32'(mif.adrs), 'h12);
    rd(8'h06, "w3_rdr_kept", 'hA5);

    din = 8'h33; mem_rd = 1; step();
    mem_rd = 0; cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
    chk("to_busy_cycles", 32'(cyc), 15);
    chk("to_err", 32'(mem_err), 1);
    rd(8'h06, "to_rdr_kept", 'hA5);
    rd(8'h0C, "to_stat", 'h1);
    step(); step();
    chk("to_err_sticky", 32'(mem_err), 1);

    mem_rd = 1; step();
    mem_rd = 0; step();
    chk("rst_mid_busy_pre", 32'(busy), 1);
    #2 reset_N = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mif.mem_req), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_err", 32'(mem_err), 0);
    chk("rst_mid_io", 32'(io_out), 0);
    chk("rst_mid_i", 32'(I), 0);
    chk("rst_mid_szcv", 32'(SZCV), 0);
    chk("rst_mid_adrs", 32'(mif.adrs), 0);
    rd(8'h0C, "rst_mid_stat", 'h0);
    rd(8'h08, "rst_mid_sp", 'hFF);
    step();
    chk("rst_mid_dout", 32'(mif.data_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
